// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a combinational instruction memory
// and fills the IF/ID register, with redirect/flush/stall handling and a sticky fault state.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] PC_MAX = 32'(IMEM_BYTES - 4);

  typedef enum logic [1:0] {BOOT, RUN, FLT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;

  logic        redir_bad, range_bad, enc_bad;
  logic        do_redirect, do_flush, capture, fault_set;
  logic [1:0]  cause_nxt;
  logic [31:0] fpc_nxt;

  assign redir_bad = redirect_target[1:0] != 2'b00;
  assign range_bad = pc > PC_MAX;
  assign enc_bad   = imem_instr[1:0] != 2'b11;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= BOOT;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (fault_set) state_nxt = FLT;
      FLT:     state_nxt = FLT;
      default: state_nxt = BOOT;
    endcase
  end

  // Per-cycle action decode; only RUN ever acts, priority redirect > flush > stall > fetch
  always_comb begin
    do_redirect = 1'b0;
    do_flush    = 1'b0;
    capture     = 1'b0;
    fault_set   = 1'b0;
    cause_nxt   = 2'b00;
    fpc_nxt     = pc;
    if (state == RUN) begin
      if (redirect_valid) begin
        if (redir_bad) begin
          fault_set = 1'b1;
          cause_nxt = 2'b01;
          fpc_nxt   = redirect_target;
        end else begin
          do_redirect = 1'b1;
        end
      end else if (flush_i) begin
        do_flush = 1'b1;
      end else if (!stall_i) begin
        if (range_bad) begin
          fault_set = 1'b1;
          cause_nxt = 2'b11;
        end else if (enc_bad) begin
          fault_set = 1'b1;
          cause_nxt = 2'b10;
        end else begin
          capture = 1'b1;
        end
      end
    end
  end

  assign imem_addr = pc;
  assign fault     = state == FLT;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc             <= RESET_PC;
      if_id_instr    <= '0;
      if_id_pc       <= '0;
      if_id_pc_plus4 <= '0;
      if_id_valid    <= 1'b0;
      fault_cause    <= 2'b00;
      fault_pc       <= '0;
      fetch_count    <= '0;
    end else begin
      if (do_redirect)  pc <= redirect_target;
      else if (capture) pc <= pc + 32'd4;

      if (capture) begin
        if_id_instr    <= imem_instr;
        if_id_pc       <= pc;
        if_id_pc_plus4 <= pc + 32'd4;
        if_id_valid    <= 1'b1;
        fetch_count    <= fetch_count + 32'd1;
      end else if (do_redirect || do_flush || fault_set) begin
        if_id_valid <= 1'b0;
      end

      if (fault_set) begin
        fault_cause <= cause_nxt;
        fault_pc    <= fpc_nxt;
      end
    end
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface. Owns the PC, drives the fetch address, and captures the returned word into the IF/ID pipeline register.
- Handles stall, flush and branch/jump redirect from later stages.
- Detects fetch faults (misaligned target, out-of-range PC, non-32-bit encoding) and parks in a sticky fault state.
- Sits between the PC/next-PC logic of the pipeline and the combinational-read instruction memory. The memory returns a word in the same cycle as the address and drives zero while in reset.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- IMEM_BYTES, 1024, byte size of the instruction memory; legal fetch PCs are 0..IMEM_BYTES-4.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low reset (asserted when 0).
- imem_addr, output, 32, byte fetch address to instruction memory; always equals the current PC.
- imem_instr, input, 32, instruction word returned combinationally for imem_addr.
- stall_i, input, 1, hold PC and IF/ID register.
- flush_i, input, 1, kill the IF/ID entry and the current fetch.
- redirect_valid, input, 1, load a new PC (taken branch, jal, jalr).
- redirect_target, input, 32, byte target of the redirect.
- if_id_instr, output, 32, captured instruction.
- if_id_pc, output, 32, PC of the captured instruction.
- if_id_pc_plus4, output, 32, if_id_pc+4, used as the jal/jalr link value.
- if_id_valid, output, 1, IF/ID holds a live instruction.
- fault, output, 1, sticky fetch fault.
- fault_cause, output, 2, 00 none, 01 misaligned redirect, 10 non-32-bit encoding, 11 PC out of range.
- fault_pc, output, 32, offending address.
- fetch_count, output, 32, number of instructions captured into IF/ID.

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=RESET_PC; state=BOOT.
  - if_id_instr, if_id_pc, if_id_pc_plus4, fault_pc and fetch_count = 0.
  - if_id_valid=0, fault=0, fault_cause=00.
  - Reset mid-operation aborts everything immediately; nothing survives.
- States:
  - BOOT: lasts exactly one cycle after reset release, because memory output is not trusted on that edge. No capture, PC holds. Next state is RUN.
  - RUN: normal fetch.
  - FAULT: terminal until reset.
- RUN per rising edge, highest priority first:
  1. redirect_valid=1, also overrides stall_i and flush_i:
     - If redirect_target[1:0]!=00: enter FAULT, fault_cause=01, fault_pc=redirect_target, if_id_valid<=0.
     - Else PC<=redirect_target, if_id_valid<=0. The word fetched this cycle is discarded, giving a 1-cycle bubble.
  2. flush_i=1: if_id_valid<=0; PC holds, so the same address is refetched next cycle.
  3. stall_i=1: PC and all IF/ID outputs hold; fetch_count holds.
  4. Otherwise, fetch:
     - If PC>IMEM_BYTES-4: FAULT, cause=11, fault_pc=PC.
     - Else if imem_instr[1:0]!=2'b11: FAULT, cause=10, fault_pc=PC.
     - Otherwise: if_id_instr<=imem_instr, if_id_pc<=PC, if_id_pc_plus4<=PC+4, if_id_valid<=1, fetch_count+=1, PC<=PC+4.
  - Fault checks: the range check takes precedence over the encoding check. No check is applied to stalled or flushed cycles.
- FAULT state:
  - fault=1; fault_cause and fault_pc frozen; if_id_valid=0.
  - PC and imem_addr frozen; all inputs ignored.
- Arithmetic:
  - PC+4 and fetch_count wrap modulo 2^32.
  - PC[1:0] is always 00 outside FAULT.
- Latency: an instruction at address A appears on the IF/ID outputs on the edge that fetched A, which is 1 cycle after imem_addr=A. Sustained throughput is 1 instruction per cycle.

Test Plan:
- Reset release, memory words 0x00002083, 0x00402103, 0x00802183 at 0, 4, 8 -> BOOT cycle with valid=0. Then 3 consecutive captures: if_id_pc 0, 4, 8; if_id_pc_plus4 4, 8, 12; fetch_count=3.
- stall_i high 2 cycles while PC=8 -> if_id_pc stays 4 with its instr, imem_addr stays 8; after release, PC=8 is captured.
- redirect_valid with target 48 while stall_i=1 -> one bubble (valid=0), next capture if_id_pc=48; the redirect wins over stall.
- redirect_target=0x00000032 -> fault=1, cause=01, fault_pc=0x32, valid=0; later stall/redirect inputs are ignored until reset.
- Memory word 0x00000000 at PC=56 -> fault, cause=10, fault_pc=56. Separately, sequential run reaching PC=1024 -> cause=11, fault_pc=1024.
- Assert reset (0) mid-stream with valid=1, fetch_count=5 -> all outputs clear immediately. After release: BOOT, then fetch from RESET_PC.
